// File: rtl/geofence_pkg.sv
// Shared geofence datapath types: coordinates, differences and cross-product results.
package geofence_pkg;

   localparam int COORD_W   = 11;
   localparam int XPROD_LAT = 2;

   typedef logic signed [COORD_W-1:0]   coord_t;
   typedef logic signed [COORD_W:0]     diff_t;
   typedef logic signed [2*COORD_W+1:0] xprod_t;

endpackage

// File: rtl/xprod_pipe.sv
// Pipelined signed (a-b)*(c-d) unit with a tag sideband; advances every cycle, no stalls.
module xprod_pipe #(
   parameter int W   = 11,
   parameter int LAT = 2,
   parameter int TW  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [TW-1:0]       in_tag,
   input  logic [W-1:0]        in_a,
   input  logic [W-1:0]        in_b,
   input  logic [W-1:0]        in_c,
   input  logic [W-1:0]        in_d,
   output logic                out_valid,
   output logic [TW-1:0]       out_tag,
   output logic [2*W+1:0]      out_prod,
   output logic                busy
);

   localparam int PW = 2*W+2;

   logic signed [W:0]    da_d, da_q, dc_d, dc_q;
   logic [LAT-1:0]       vld_d, vld_q;
   logic [TW-1:0]        tag_d [LAT];
   logic [TW-1:0]        tag_q [LAT];
   logic signed [PW-1:0] prod_c;

   always_comb begin
      da_d = da_q;
      dc_d = dc_q;
      if (in_valid) begin
         da_d = {in_a[W-1], in_a} - {in_b[W-1], in_b};
         dc_d = {in_c[W-1], in_c} - {in_d[W-1], in_d};
      end
      vld_d    = '0;
      vld_d[0] = in_valid;
      tag_d[0] = in_tag;
      for (int s = 1; s < LAT; s++) begin
         vld_d[s] = vld_q[s-1];
         tag_d[s] = tag_q[s-1];
      end
   end

   // Full-width operands so the product of two (W+1)-bit values cannot overflow.
   assign prod_c = PW'(da_q) * PW'(dc_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         da_q  <= '0;
         dc_q  <= '0;
         vld_q <= '0;
         for (int s = 0; s < LAT; s++) tag_q[s] <= '0;
      end else begin
         da_q  <= da_d;
         dc_q  <= dc_d;
         vld_q <= vld_d;
         tag_q <= tag_d;
      end
   end

   generate
      if (LAT == 1) begin : g_lat1
         logic signed [PW-1:0] hold_d, hold_q;

         always_comb begin
            hold_d = vld_q[0] ? prod_c : hold_q;
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) hold_q <= '0;
            else       hold_q <= hold_d;
         end

         assign out_prod = vld_q[0] ? prod_c : hold_q;
      end else begin : g_latn
         // Product stages load only behind a valid, so the last stage keeps the last result.
         logic signed [PW-1:0] prod_d [1:LAT-1];
         logic signed [PW-1:0] prod_q [1:LAT-1];

         always_comb begin
            prod_d[1] = vld_q[0] ? prod_c : prod_q[1];
            for (int s = 2; s < LAT; s++) begin
               prod_d[s] = vld_q[s-1] ? prod_q[s-1] : prod_q[s];
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int s = 1; s < LAT; s++) prod_q[s] <= '0;
            end else begin
               prod_q <= prod_d;
            end
         end

         assign out_prod = prod_q[LAT-1];
      end
   endgenerate

   assign out_valid = vld_q[LAT-1];
   assign out_tag   = tag_q[LAT-1];
   assign busy      = |vld_q;

endmodule

// File: rtl/xprod_arbiter.sv
// Round-robin arbiter sharing one xprod_pipe among NREQ requesters; results return tagged, one-hot.
// Define XPROD_ARB_LOCK_EN to let a requester keep the grant for back-to-back operations.
module xprod_arbiter
   import geofence_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int W    = COORD_W,
   parameter int LAT  = XPROD_LAT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ-1:0]     req_lock,
   input  logic [NREQ*W-1:0]   req_a,
   input  logic [NREQ*W-1:0]   req_b,
   input  logic [NREQ*W-1:0]   req_c,
   input  logic [NREQ*W-1:0]   req_d,
   output logic [NREQ-1:0]     rsp_valid,
   output logic [2*W+1:0]      rsp_data,
   output logic                busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0] ptr_d, ptr_q;
   logic [IW-1:0] gnt_idx, idx;
   logic          found, hs;
   logic [W-1:0]  sel_a, sel_b, sel_c, sel_d;
   logic          pipe_vld;
   logic [IW-1:0] pipe_tag;

`ifdef XPROD_ARB_LOCK_EN
   logic          lock_vld_d, lock_vld_q;
   logic [IW-1:0] lock_own_d, lock_own_q;
`else
   logic          unused_lock;
   assign unused_lock = ^req_lock;
`endif

   always_comb begin
      found   = 1'b0;
      gnt_idx = ptr_q;
      idx     = '0;
      // Search starts one past the last grant, wrapping modulo NREQ.
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(ptr_q) + i) % NREQ);
         if (!found && req_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
`ifdef XPROD_ARB_LOCK_EN
      if (lock_vld_q && req_valid[lock_own_q]) begin
         found   = 1'b1;
         gnt_idx = lock_own_q;
      end
`endif
      hs        = found && !reset;
      req_ready = '0;
      if (hs) req_ready[gnt_idx] = 1'b1;
      ptr_d = hs ? gnt_idx : ptr_q;

      sel_a = req_a[int'(gnt_idx)*W +: W];
      sel_b = req_b[int'(gnt_idx)*W +: W];
      sel_c = req_c[int'(gnt_idx)*W +: W];
      sel_d = req_d[int'(gnt_idx)*W +: W];
   end

`ifdef XPROD_ARB_LOCK_EN
   always_comb begin
      lock_vld_d = lock_vld_q;
      lock_own_d = lock_own_q;
      if (hs) begin
         lock_vld_d = req_lock[gnt_idx];
         lock_own_d = gnt_idx;
      end else if (!req_valid[lock_own_q]) begin
         lock_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_vld_q <= 1'b0;
         lock_own_q <= '0;
      end else begin
         lock_vld_q <= lock_vld_d;
         lock_own_q <= lock_own_d;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= IW'(NREQ-1);
      else       ptr_q <= ptr_d;
   end

   xprod_pipe #(
      .W   (W),
      .LAT (LAT),
      .TW  (IW)
   ) u_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (hs),
      .in_tag    (gnt_idx),
      .in_a      (sel_a),
      .in_b      (sel_b),
      .in_c      (sel_c),
      .in_d      (sel_d),
      .out_valid (pipe_vld),
      .out_tag   (pipe_tag),
      .out_prod  (rsp_data),
      .busy      (busy)
   );

   always_comb begin
      rsp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_valid[i] = pipe_vld && (pipe_tag == IW'(i));
      end
   end

endmodule

// File: tb/tb_xprod_arbiter.sv
// Directed bench for xprod_arbiter (NREQ=4, W=11, LAT=2) with a result scoreboard.
module tb_xprod_arbiter;
   import geofence_pkg::*;

   localparam int NREQ = 4;
   localparam int W    = 11;
   localparam int LAT  = 2;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic [NREQ-1:0]     req_valid = '0;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ-1:0]     req_lock = '0;
   logic [NREQ*W-1:0]   req_a, req_b, req_c, req_d;
   logic [NREQ-1:0]     rsp_valid;
   logic [2*W+1:0]      rsp_data;
   logic                busy;

   coord_t op_a [NREQ];
   coord_t op_b [NREQ];
   coord_t op_c [NREQ];
   coord_t op_d [NREQ];

   typedef struct {
      logic [NREQ-1:0] oh;
      xprod_t          prod;
      int              due;
   } exp_t;

   exp_t   sb [$];
   int     edge_n   = 0;
   int     n_tests  = 0;
   int     n_fail   = 0;
   xprod_t last_data = '0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*W +: W] = op_a[i];
         req_b[i*W +: W] = op_b[i];
         req_c[i*W +: W] = op_c[i];
         req_d[i*W +: W] = op_d[i];
      end
   end

   xprod_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_lock  (req_lock),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_c     (req_c),
      .req_d     (req_d),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic xprod_t model_prod(input int g);
      int da, dc;
      da = int'(op_a[g]) - int'(op_b[g]);
      dc = int'(op_c[g]) - int'(op_d[g]);
      return xprod_t'(da * dc);
   endfunction

   task automatic set_ops(input int g, input int a, input int b, input int c, input int d);
      op_a[g] = coord_t'(a);
      op_b[g] = coord_t'(b);
      op_c[g] = coord_t'(c);
      op_d[g] = coord_t'(d);
   endtask

   task automatic rand_ops(input int g);
      op_a[g] = coord_t'($urandom);
      op_b[g] = coord_t'($urandom);
      op_c[g] = coord_t'($urandom);
      op_d[g] = coord_t'($urandom);
   endtask

   // One clock: check the grant before the edge, push the expected result, check outputs after.
   task automatic cycle(input logic [NREQ-1:0] exp_gnt);
      exp_t e;
      @(negedge clk);
      chk("req_ready", 64'(req_ready), 64'(exp_gnt));
      if (exp_gnt != '0) begin
         for (int i = 0; i < NREQ; i++) begin
            if (exp_gnt[i]) begin
               e.oh   = exp_gnt;
               e.prod = model_prod(i);
               e.due  = edge_n + LAT;
               sb.push_back(e);
            end
         end
      end
      @(posedge clk);
      edge_n++;
      #1;
      chk("busy", 64'(busy), 64'(sb.size() != 0));
      if (sb.size() != 0 && sb[0].due == edge_n) begin
         e = sb.pop_front();
         chk("rsp_valid", 64'(rsp_valid), 64'(e.oh));
         chk("rsp_data", 64'($signed(rsp_data)), 64'(e.prod));
         last_data = e.prod;
      end else begin
         chk("rsp_valid_idle", 64'(rsp_valid), 64'(0));
         chk("rsp_data_hold", 64'($signed(rsp_data)), 64'(last_data));
      end
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) set_ops(i, i + 1, 0, i + 2, 0);

      // Reset state, with every requester asking
      req_valid = '1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_data", 64'(rsp_data), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      reset = 1'b0;

      // Round-robin: grants 0,1,2,3,0,1,2,3
      for (int i = 0; i < 8; i++) begin
         cycle(NREQ'(1 << (i % NREQ)));
         rand_ops(i % NREQ);
      end
      req_valid = '0;
      repeat (3) cycle('0);

      // Single request from requester 2
      set_ops(2, 5, 1, 3, 10);
      req_valid = 4'b0100;
      cycle(4'b0100);
      req_valid = '0;
      cycle('0);
      chk("single_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
      chk("single_rsp_data", 64'($signed(rsp_data)), 64'(-28));
      cycle('0);
      chk("single_busy_done", 64'(busy), 64'(0));

      // Extreme operands, both signs
      set_ops(0, 1023, -1024, -1024, 1023);
      req_valid = 4'b0001;
      cycle(4'b0001);
      set_ops(0, -1024, 1023, -1024, 1023);
      cycle(4'b0001);
      chk("extreme_neg", 64'($signed(rsp_data)), 64'(-4190209));
      req_valid = '0;
      cycle('0);
      chk("extreme_pos", 64'($signed(rsp_data)), 64'(4190209));
      repeat (2) cycle('0);

      // Lock: requester 1 issues two operations while requester 0 waits
      set_ops(0, 7, 2, -3, 4);
      set_ops(1, 9, -9, 2, 6);
      req_valid = 4'b0011;
      req_lock  = 4'b0010;
      cycle(4'b0010);
      set_ops(1, -100, 50, 300, -20);
      req_lock  = 4'b0000;
`ifdef XPROD_ARB_LOCK_EN
      cycle(4'b0010);
      req_valid = 4'b0001;
      cycle(4'b0001);
`else
      cycle(4'b0001);
      req_valid = 4'b0010;
      cycle(4'b0010);
`endif
      req_valid = '0;
      repeat (3) cycle('0);

      // Streaming: requester 3 every cycle for 10 cycles
      req_valid = 4'b1000;
      for (int i = 0; i < 10; i++) begin
         rand_ops(3);
         cycle(4'b1000);
      end
      req_valid = '0;
      repeat (3) cycle('0);
      chk("stream_hold", 64'($signed(rsp_data)), 64'(last_data));

      // Reset mid-flight
      req_valid = 4'b0110;
      cycle(4'b0010);
      rand_ops(1);
      cycle(4'b0100);
      reset = 1'b1;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_rsp_data", 64'(rsp_data), 64'(0));
      sb.delete();
      last_data = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_req_ready", 64'(req_ready), 64'(0));
         @(posedge clk);
         #1;
         chk("midrst_rsp_hold", 64'(rsp_valid), 64'(0));
      end
      reset = 1'b0;
      req_valid = 4'b1111;
      cycle(4'b0001);
      req_valid = '0;
      repeat (3) cycle('0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
